wb_ppfifo_to_mem: RTL and testbench

Wishbone-master DMA writer that drains a ping-pong-FIFO read port into system memory through two host-armed buffers. Used as the capture backend of a camera core, and by any streaming source that hands data over in FIFO blocks. The host arms buffer 0 or 1 with a base address and a size. The block fills the armed buffers alternately and reports fill count, finished and empty per buffer. A flush strobe closes a partially filled buffer at end-of-frame.

---
 rtl/wb_ppfifo_to_mem_pkg.sv | 20 ++
 rtl/wb_ppfifo_to_mem_if.sv | 32 +++
 rtl/wb_ppfifo_to_mem_buffer_ctrl.sv | 34 +++
 rtl/wb_ppfifo_to_mem.sv | 205 ++++++++++++++++++++
 tb/tb_wb_ppfifo_to_mem.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_ppfifo_to_mem_pkg.sv
// Shared definitions for the ping-pong-FIFO to memory DMA writer.
package wb_ppfifo_to_mem_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACTIVATE = 3'd1,
    READ     = 3'd2,
    WB_WRITE = 3'd3,
    WB_ACK   = 3'd4,
    WAIT_BUF = 3'd5
  } state_t;

  localparam int unsigned DBG_STATE_LSB  = 0;
  localparam int unsigned DBG_ACTIVE_BIT = 3;
  localparam int unsigned DBG_ACT_BIT    = 4;

  localparam logic [31:0] DEF_MEM_0_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_MEM_1_BASE = 32'h0010_0000;

endpackage

// File: rtl/wb_ppfifo_to_mem_if.sv
// Wishbone master bus plus ping-pong FIFO read port.
interface wb_ppfifo_to_mem_if;
  logic        o_mem_we;
  logic        o_mem_stb;
  logic        o_mem_cyc;
  logic [3:0]  o_mem_sel;
  logic [31:0] o_mem_adr;
  logic [31:0] o_mem_dat;
  logic [31:0] i_mem_dat;
  logic        i_mem_ack;
  logic        i_mem_int;

  logic        i_ppfifo_rdy;
  logic        o_ppfifo_act;
  logic [23:0] i_ppfifo_size;
  logic        o_ppfifo_stb;
  logic [31:0] i_ppfifo_data;

  modport master (
    output o_mem_we, o_mem_stb, o_mem_cyc, o_mem_sel, o_mem_adr, o_mem_dat,
    input  i_mem_dat, i_mem_ack, i_mem_int,
    input  i_ppfifo_rdy, i_ppfifo_size, i_ppfifo_data,
    output o_ppfifo_act, o_ppfifo_stb
  );

  modport slave (
    input  o_mem_we, o_mem_stb, o_mem_cyc, o_mem_sel, o_mem_adr, o_mem_dat,
    output i_mem_dat, i_mem_ack, i_mem_int,
    output i_ppfifo_rdy, i_ppfifo_size, i_ppfifo_data,
    input  o_ppfifo_act, o_ppfifo_stb
  );
endinterface

// File: rtl/wb_ppfifo_to_mem_buffer_ctrl.sv
// Per-buffer arm / fill-count / finished register set.
module wb_ppfifo_to_mem_buffer_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [31:0] size,
  input  logic        inc,
  input  logic        finish,
  output logic        armed,
  output logic [31:0] count,
  output logic        finished
);

  // Arming takes priority over a same-cycle word or finish; a zero size never arms.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed    <= 1'b0;
      count    <= '0;
      finished <= 1'b0;
    end else if (ready && (size != '0)) begin
      armed    <= 1'b1;
      count    <= '0;
      finished <= 1'b0;
    end else begin
      if (inc)
        count <= count + 32'd1;
      if (finish) begin
        finished <= 1'b1;
        armed    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_ppfifo_to_mem.sv
// Wishbone DMA writer draining a ping-pong FIFO into two host-armed buffers.
module wb_ppfifo_to_mem
  import wb_ppfifo_to_mem_pkg::*;
#(
  parameter logic [31:0] DEFAULT_MEM_0_BASE = DEF_MEM_0_BASE,
  parameter logic [31:0] DEFAULT_MEM_1_BASE = DEF_MEM_1_BASE
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] debug,
  input  logic        i_enable,
  input  logic        i_flush,
  input  logic [31:0] i_memory_0_base,
  input  logic [31:0] i_memory_0_size,
  input  logic        i_memory_0_ready,
  output logic [31:0] o_memory_0_count,
  output logic        o_memory_0_finished,
  output logic        o_memory_0_empty,
  input  logic [31:0] i_memory_1_base,
  input  logic [31:0] i_memory_1_size,
  input  logic        i_memory_1_ready,
  output logic [31:0] o_memory_1_count,
  output logic        o_memory_1_finished,
  output logic        o_memory_1_empty,
  output logic [31:0] o_default_mem_0_base,
  output logic [31:0] o_default_mem_1_base,
  output logic        o_write_finished,
  wb_ppfifo_to_mem_if.master bus
);

  state_t      state, state_next;
  logic        active;
  logic        flush_pend;
  logic [23:0] block_size;
  logic [23:0] word_cnt;
  logic [31:0] data_q;

  logic        claim, release_blk, fetch, issue, acked, do_flush, switch_buf;
  logic        armed0, armed1;
  logic        act_armed, oth_armed, full, flush_eff, finish_act;
  logic [31:0] act_count, act_size, act_base;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.i_mem_dat, bus.i_mem_int};

  assign o_default_mem_0_base = DEFAULT_MEM_0_BASE;
  assign o_default_mem_1_base = DEFAULT_MEM_1_BASE;
  assign o_memory_0_empty     = !armed0;
  assign o_memory_1_empty     = !armed1;

  assign act_armed  = active ? armed1 : armed0;
  assign oth_armed  = active ? armed0 : armed1;
  assign act_count  = active ? o_memory_1_count : o_memory_0_count;
  assign act_size   = active ? i_memory_1_size  : i_memory_0_size;
  assign act_base   = active ? i_memory_1_base  : i_memory_0_base;
  assign full       = (act_count + 32'd1) == act_size;
  assign flush_eff  = do_flush && act_armed && (act_count != '0);
  assign finish_act = (acked && full) || flush_eff;

  wb_ppfifo_to_mem_buffer_ctrl u_buf0 (
    .clk      (clk),
    .rst      (rst),
    .ready    (i_memory_0_ready),
    .size     (i_memory_0_size),
    .inc      (acked && !active),
    .finish   (finish_act && !active),
    .armed    (armed0),
    .count    (o_memory_0_count),
    .finished (o_memory_0_finished)
  );

  wb_ppfifo_to_mem_buffer_ctrl u_buf1 (
    .clk      (clk),
    .rst      (rst),
    .ready    (i_memory_1_ready),
    .size     (i_memory_1_size),
    .inc      (acked && active),
    .finish   (finish_act && active),
    .armed    (armed1),
    .count    (o_memory_1_count),
    .finished (o_memory_1_finished)
  );

  // Debug word: state, active buffer, FIFO claim.
  always_comb begin
    debug = '0;
    debug[DBG_STATE_LSB +: 3] = state;
    debug[DBG_ACTIVE_BIT]     = active;
    debug[DBG_ACT_BIT]        = bus.o_ppfifo_act;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and one-cycle control enables; a pending flush owns the whole
  // cycle so the buffer toggle never races the armed check in the same cycle.
  always_comb begin
    state_next  = state;
    claim       = 1'b0;
    release_blk = 1'b0;
    fetch       = 1'b0;
    issue       = 1'b0;
    acked       = 1'b0;
    do_flush    = 1'b0;
    switch_buf  = 1'b0;
    case (state)
      IDLE: begin
        if (flush_pend)
          do_flush = 1'b1;
        else if (i_enable && bus.i_ppfifo_rdy && !bus.o_ppfifo_act) begin
          claim      = 1'b1;
          state_next = ACTIVATE;
        end
      end
      ACTIVATE, READ: begin
        if (flush_pend)
          do_flush = 1'b1;
        else if ((word_cnt == block_size) || !i_enable) begin
          release_blk = 1'b1;
          state_next  = IDLE;
        end else if (!act_armed)
          state_next = WAIT_BUF;
        else begin
          fetch      = 1'b1;
          state_next = WB_WRITE;
        end
      end
      WB_WRITE: begin
        issue      = 1'b1;
        state_next = WB_ACK;
      end
      WB_ACK: begin
        if (bus.i_mem_ack) begin
          acked      = 1'b1;
          state_next = READ;
        end
      end
      WAIT_BUF: begin
        if (flush_pend)
          do_flush = 1'b1;
        else if (act_armed)
          state_next = READ;
        else if (oth_armed) begin
          switch_buf = 1'b1;
          state_next = READ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered bus/FIFO outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      active           <= 1'b0;
      flush_pend       <= 1'b0;
      block_size       <= '0;
      word_cnt         <= '0;
      data_q           <= '0;
      o_write_finished <= 1'b0;
      bus.o_ppfifo_act <= 1'b0;
      bus.o_ppfifo_stb <= 1'b0;
      bus.o_mem_cyc    <= 1'b0;
      bus.o_mem_stb    <= 1'b0;
      bus.o_mem_we     <= 1'b0;
      bus.o_mem_sel    <= '0;
      bus.o_mem_adr    <= '0;
      bus.o_mem_dat    <= '0;
    end else begin
      flush_pend       <= i_flush || (flush_pend && !do_flush);
      o_write_finished <= finish_act;
      bus.o_ppfifo_stb <= fetch;
      if (claim) begin
        bus.o_ppfifo_act <= 1'b1;
        block_size       <= bus.i_ppfifo_size;
        word_cnt         <= '0;
      end
      if (release_blk)
        bus.o_ppfifo_act <= 1'b0;
      if (fetch)
        data_q <= bus.i_ppfifo_data;
      if (issue) begin
        bus.o_mem_cyc <= 1'b1;
        bus.o_mem_stb <= 1'b1;
        bus.o_mem_we  <= 1'b1;
        bus.o_mem_sel <= 4'hF;
        bus.o_mem_adr <= act_base + act_count;
        bus.o_mem_dat <= data_q;
      end
      if (acked) begin
        bus.o_mem_cyc <= 1'b0;
        bus.o_mem_stb <= 1'b0;
        bus.o_mem_we  <= 1'b0;
        bus.o_mem_sel <= '0;
        word_cnt      <= word_cnt + 24'd1;
      end
      if (finish_act || switch_buf)
        active <= !active;
    end
  end

endmodule

// File: tb/tb_wb_ppfifo_to_mem.sv
// Directed scoreboard bench for wb_ppfifo_to_mem.
module tb_wb_ppfifo_to_mem;
  import wb_ppfifo_to_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] debug;
  logic        i_enable = 1'b1;
  logic        i_flush = 1'b0;
  logic [31:0] i_memory_0_base = '0, i_memory_0_size = '0;
  logic [31:0] i_memory_1_base = '0, i_memory_1_size = '0;
  logic        i_memory_0_ready = 1'b0, i_memory_1_ready = 1'b0;
  logic [31:0] o_memory_0_count, o_memory_1_count;
  logic        o_memory_0_finished, o_memory_1_finished;
  logic        o_memory_0_empty, o_memory_1_empty;
  logic [31:0] o_default_mem_0_base, o_default_mem_1_base;
  logic        o_write_finished;

  wb_ppfifo_to_mem_if bus ();

  wb_ppfifo_to_mem #(
    .DEFAULT_MEM_0_BASE(32'h0000_0000),
    .DEFAULT_MEM_1_BASE(32'h0010_0000)
  ) dut (
    .clk(clk), .rst(rst), .debug(debug),
    .i_enable(i_enable), .i_flush(i_flush),
    .i_memory_0_base(i_memory_0_base), .i_memory_0_size(i_memory_0_size),
    .i_memory_0_ready(i_memory_0_ready), .o_memory_0_count(o_memory_0_count),
    .o_memory_0_finished(o_memory_0_finished), .o_memory_0_empty(o_memory_0_empty),
    .i_memory_1_base(i_memory_1_base), .i_memory_1_size(i_memory_1_size),
    .i_memory_1_ready(i_memory_1_ready), .o_memory_1_count(o_memory_1_count),
    .o_memory_1_finished(o_memory_1_finished), .o_memory_1_empty(o_memory_1_empty),
    .o_default_mem_0_base(o_default_mem_0_base),
    .o_default_mem_1_base(o_default_mem_1_base),
    .o_write_finished(o_write_finished),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned checks = 0, passed = 0, fails = 0;
  int unsigned ack_delay = 0;
  int unsigned stb_count = 0, blk_start = 0, wf_count = 0, wf_base = 0;
  logic [31:0] fifo_mem [16];
  logic        act_seen, cyc_seen;

  assign bus.i_ppfifo_data = fifo_mem[4'(stb_count - blk_start)];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] adr, input logic [31:0] dat);
    wr_t w;
    w.adr = adr;
    w.dat = dat;
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_enable = 1'b1;
    i_flush = 1'b0;
    bus.i_ppfifo_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    wf_base = wf_count;
  endtask

  task automatic arm(input int unsigned n, input logic [31:0] base, input logic [31:0] size);
    @(negedge clk);
    if (n == 0) begin
      i_memory_0_base = base; i_memory_0_size = size; i_memory_0_ready = 1'b1;
    end else begin
      i_memory_1_base = base; i_memory_1_size = size; i_memory_1_ready = 1'b1;
    end
    @(negedge clk);
    i_memory_0_ready = 1'b0;
    i_memory_1_ready = 1'b0;
  endtask

  task automatic start_block(input int unsigned n, input logic [31:0] first);
    int unsigned k = 0;
    for (int unsigned i = 0; i < n; i++) fifo_mem[i] = first + i;
    blk_start = stb_count;
    bus.i_ppfifo_size = 24'(n);
    bus.i_ppfifo_rdy = 1'b1;
    while (!bus.o_ppfifo_act && k < 50) begin @(negedge clk); k++; end
    check("act_rise", 32'(bus.o_ppfifo_act), 1);
    bus.i_ppfifo_rdy = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    while (bus.o_ppfifo_act && k < 400) begin @(negedge clk); k++; end
    check("act_fall", 32'(bus.o_ppfifo_act), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // FIFO consumption and finish-pulse counter.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_ppfifo_stb) stb_count++;
      if (o_write_finished) wf_count++;
    end
  end

  // Memory slave: acks after ack_delay cycles and scores each write.
  initial begin
    wr_t e;
    bus.i_mem_ack = 1'b0;
    bus.i_mem_dat = '0;
    bus.i_mem_int = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_mem_cyc && bus.o_mem_stb && !rst) begin
        if (exp_q.size() == 0)
          check("wr_unexpected", 32'(exp_q.size()), 1);
        else begin
          e = exp_q[0];
          if (ack_delay > 0) begin
            check("adr_first", bus.o_mem_adr, e.adr);
            check("dat_first", bus.o_mem_dat, e.dat);
            repeat (ack_delay) @(negedge clk);
            check("cyc_held", 32'(bus.o_mem_cyc && bus.o_mem_stb), 1);
          end
          check("wr_adr", bus.o_mem_adr, e.adr);
          check("wr_dat", bus.o_mem_dat, e.dat);
          check("wr_sel_we", {27'd0, bus.o_mem_sel, bus.o_mem_we}, {27'd0, 4'hF, 1'b1});
          void'(exp_q.pop_front());
        end
        bus.i_mem_ack = 1'b1;
        @(negedge clk);
        bus.i_mem_ack = 1'b0;
      end
    end
  end

  initial begin
    bus.i_ppfifo_rdy = 1'b0;
    bus.i_ppfifo_size = '0;
    for (int unsigned i = 0; i < 16; i++) fifo_mem[i] = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_debug", debug, 0);
    check("rst_empty", {30'd0, o_memory_1_empty, o_memory_0_empty}, 3);
    check("rst_counts", o_memory_0_count | o_memory_1_count, 0);
    check("rst_flags", {28'd0, o_memory_0_finished, o_memory_1_finished, o_write_finished,
                        bus.o_ppfifo_act}, 0);
    check("rst_bus", {29'd0, bus.o_mem_cyc, bus.o_mem_stb, bus.o_ppfifo_stb}, 0);
    check("def_base0", o_default_mem_0_base, 32'h0000_0000);
    check("def_base1", o_default_mem_1_base, 32'h0010_0000);
    do_reset();

    // Single block fills buffer 0 exactly.
    arm(0, 32'h100, 4);
    for (int unsigned i = 0; i < 4; i++) push(32'h100 + i, 32'hA0 + i);
    start_block(4, 32'hA0);
    wait_idle();
    check("t1_count0", o_memory_0_count, 4);
    check("t1_fin0", 32'(o_memory_0_finished), 1);
    check("t1_empty0", 32'(o_memory_0_empty), 1);
    check("t1_wf", wf_count - wf_base, 1);
    check("t1_q", 32'(exp_q.size()), 0);
    check("t1_active", 32'(debug[3]), 1);

    // Block spans both buffers.
    do_reset();
    arm(0, 32'h100, 4);
    arm(1, 32'h200, 4);
    for (int unsigned i = 0; i < 4; i++) push(32'h100 + i, 32'hB0 + i);
    push(32'h200, 32'hB4);
    push(32'h201, 32'hB5);
    start_block(6, 32'hB0);
    wait_idle();
    check("t2_count0", o_memory_0_count, 4);
    check("t2_count1", o_memory_1_count, 2);
    check("t2_fin", {30'd0, o_memory_0_finished, o_memory_1_finished}, 2);
    check("t2_empty1", 32'(o_memory_1_empty), 0);
    check("t2_wf", wf_count - wf_base, 1);
    check("t2_q", 32'(exp_q.size()), 0);

    // Stall in WAIT_BUF until buffer 1 is armed.
    do_reset();
    arm(0, 32'h100, 4);
    for (int unsigned i = 0; i < 4; i++) push(32'h100 + i, 32'hC0 + i);
    for (int unsigned i = 0; i < 4; i++) push(32'h300 + i, 32'hC4 + i);
    start_block(8, 32'hC0);
    for (int unsigned k = 0; k < 100 && !o_memory_0_finished; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("t3_state", 32'(debug[2:0]), 32'(WAIT_BUF));
    check("t3_act", 32'(bus.o_ppfifo_act), 1);
    check("t3_count0", o_memory_0_count, 4);
    check("t3_q", 32'(exp_q.size()), 4);
    arm(1, 32'h300, 4);
    wait_idle();
    check("t3_count1", o_memory_1_count, 4);
    check("t3_fin1", 32'(o_memory_1_finished), 1);
    check("t3_wf", wf_count - wf_base, 2);
    check("t3_q_end", 32'(exp_q.size()), 0);

    // Flush a partially filled buffer, then a no-op flush.
    do_reset();
    arm(0, 32'h100, 10);
    for (int unsigned i = 0; i < 3; i++) push(32'h100 + i, 32'hD0 + i);
    start_block(3, 32'hD0);
    wait_idle();
    check("t4_pre_fin0", 32'(o_memory_0_finished), 0);
    pulse_flush();
    check("t4_fin0", 32'(o_memory_0_finished), 1);
    check("t4_count0", o_memory_0_count, 3);
    check("t4_empty0", 32'(o_memory_0_empty), 1);
    check("t4_active", 32'(debug[3]), 1);
    check("t4_wf", wf_count - wf_base, 1);
    arm(1, 32'h200, 5);
    pulse_flush();
    check("t4_noop_fin1", 32'(o_memory_1_finished), 0);
    check("t4_noop_empty1", 32'(o_memory_1_empty), 0);
    check("t4_noop_active", 32'(debug[3]), 1);
    check("t4_noop_wf", wf_count - wf_base, 1);

    // Slow acknowledge.
    do_reset();
    ack_delay = 5;
    arm(0, 32'h400, 2);
    push(32'h400, 32'hE0);
    push(32'h401, 32'hE1);
    start_block(2, 32'hE0);
    wait_idle();
    ack_delay = 0;
    check("t5_count0", o_memory_0_count, 2);
    check("t5_stb", stb_count - blk_start, 2);
    check("t5_wf", wf_count - wf_base, 1);

    // Disabled block ignores a ready FIFO.
    do_reset();
    arm(0, 32'h500, 4);
    i_enable = 1'b0;
    bus.i_ppfifo_size = 24'd2;
    bus.i_ppfifo_rdy = 1'b1;
    act_seen = 1'b0;
    cyc_seen = 1'b0;
    for (int unsigned k = 0; k < 20; k++) begin
      @(negedge clk);
      act_seen |= bus.o_ppfifo_act;
      cyc_seen |= bus.o_mem_cyc;
    end
    check("t6_act", 32'(act_seen), 0);
    check("t6_cyc", 32'(cyc_seen), 0);
    check("t6_count0", o_memory_0_count, 0);
    bus.i_ppfifo_rdy = 1'b0;
    i_enable = 1'b1;

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
